// File: rtl/ustream_win_count.sv
// rtl/ustream_win_count.sv - windowed 1s counter for a unary bitstream
// Counts 1s over 2^WIDTH enabled samples; the result is released through valid/ready.
module ustream_win_count #(
  parameter int WIDTH   = 8,
  parameter int LOGINUM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     en,
  input  logic                     in,
  input  logic                     ready,
  output logic                     busy,
  output logic                     valid,
  output logic [WIDTH:0]           cnt_out,
  output logic [WIDTH+LOGINUM:0]   sum_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_cyc;
  logic [WIDTH:0]   w_acc_next;
  logic             w_last;

  // One extra accumulator bit lets an all-ones window reach exactly 2^WIDTH.
  assign w_acc_next = r_acc + {{WIDTH{1'b0}}, in};
  assign w_last     = (r_cyc == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cyc   <= '0;
      cnt_out <= '0;
      sum_out <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          busy  <= 1'b0;
          valid <= 1'b0;
          if (start) begin
            r_state <= S_COUNT;
            r_acc   <= '0;
            r_cyc   <= '0;
            busy    <= 1'b1;
          end
        end

        S_COUNT: begin
          if (en) begin
            if (w_last) begin
              cnt_out <= w_acc_next;
              sum_out <= {w_acc_next, {LOGINUM{1'b0}}};
              r_cyc   <= '0;
              r_state <= S_HOLD;
              busy    <= 1'b0;
              valid   <= 1'b1;
            end else begin
              r_acc <= w_acc_next;
              r_cyc <= r_cyc + 1'b1;
            end
          end
        end

        S_HOLD: begin
          // Outputs stay frozen until the consumer takes them.
          if (ready) begin
            valid <= 1'b0;
            if (start) begin
              r_state <= S_COUNT;
              r_acc   <= '0;
              r_cyc   <= '0;
              busy    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ustream_win_count.sv
// tb/tb_ustream_win_count.sv - scoreboard bench for ustream_win_count
module tb_ustream_win_count;
  localparam int W = 8;
  localparam int L = 2;
  localparam int N = 1 << W;

  typedef struct packed {
    logic [W:0]   c;
    logic [W+L:0] s;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, en, in_bit, ready;
  logic         busy, valid;
  logic [W:0]   cnt_out;
  logic [W+L:0] sum_out;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ustream_win_count #(.WIDTH(W), .LOGINUM(L)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .in      (in_bit),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .cnt_out (cnt_out),
    .sum_out (sum_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 2 == 0);
      default: return (k < 64);
    endcase
  endfunction

  // Monitor: pops one expected result per valid&ready handshake.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cnt_out", cnt_out, e.c);
          chk("sum_out", sum_out, e.s);
        end
      end
    end
  end

  task automatic kick();
    @(posedge clk); #1;
    start  = 1'b1;
    en     = 1'b1;
    in_bit = 1'b1;
  endtask

  task automatic window(input int pat, input bit en_tog, input res_t e,
                        input bit check_prev, input logic [W:0] prev);
    int k, cyc, bad_busy, bad_prev;
    bit ph;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0; cyc = 0; ph = 1'b0; bad_busy = 0; bad_prev = 0;
    while (k < N && cyc < 4 * N) begin
      en     = en_tog ? ph : 1'b1;
      ph     = ~ph;
      in_bit = en ? pat_bit(pat, k) : ~pat_bit(pat, k);
      @(posedge clk); #1;
      cyc++;
      if (en) k++;
      if (k < N) begin
        if (busy !== 1'b1 || valid !== 1'b0) bad_busy++;
        if (check_prev && cnt_out !== prev) bad_prev++;
      end
    end
    en = 1'b1;
    chk("window_cycles", cyc, en_tog ? 2 * N : N);
    chk("busy_valid_during_window", bad_busy, 0);
    if (check_prev) chk("prev_result_held", bad_prev, 0);
    chk("valid_at_end", valid, 1);
    chk("busy_at_end", busy, 0);
  endtask

  task automatic release_res(input int hold_cycles, input bit restart, input res_t e);
    int bad;
    bad = 0;
    ready = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      start = (i % 3 == 0);
      @(posedge clk); #1;
      if (valid !== 1'b1 || busy !== 1'b0 || cnt_out !== e.c || sum_out !== e.s) bad++;
    end
    start = 1'b0;
    if (hold_cycles > 0) chk("hold_stable", bad, 0);
    ready = 1'b1;
    start = restart;
    if (!restart) begin
      @(posedge clk); #1;
      ready = 1'b0;
      chk("valid_after_release", valid, 0);
      chk("busy_after_release", busy, 0);
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; en = 1'b0; in_bit = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_cnt", cnt_out, 0);
    chk("reset_sum", sum_out, 0);

    kick();
    window(0, 1'b0, res_t'{9'd256, 11'd1024}, 1'b0, '0);
    release_res(0, 1'b0, res_t'{9'd256, 11'd1024});

    kick();
    window(1, 1'b0, res_t'{9'd0, 11'd0}, 1'b0, '0);
    release_res(0, 1'b0, res_t'{9'd0, 11'd0});

    kick();
    window(2, 1'b0, res_t'{9'd128, 11'd512}, 1'b0, '0);
    release_res(0, 1'b0, res_t'{9'd128, 11'd512});

    kick();
    window(0, 1'b1, res_t'{9'd256, 11'd1024}, 1'b0, '0);
    release_res(0, 1'b0, res_t'{9'd256, 11'd1024});

    kick();
    window(0, 1'b0, res_t'{9'd256, 11'd1024}, 1'b0, '0);
    release_res(20, 1'b1, res_t'{9'd256, 11'd1024});
    window(3, 1'b0, res_t'{9'd64, 11'd256}, 1'b1, 9'd256);
    release_res(0, 1'b0, res_t'{9'd64, 11'd256});

    kick();
    @(posedge clk); #1;
    start = 1'b0; en = 1'b1; in_bit = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_cnt", cnt_out, 0);
    chk("abort_sum", sum_out, 0);
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_valid_after_abort", bad, 0);

    kick();
    window(0, 1'b0, res_t'{9'd256, 11'd1024}, 1'b0, '0);
    release_res(0, 1'b0, res_t'{9'd256, 11'd1024});

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
